// File: rtl/orion_video_pkg.sv
// Orion video control-port constants and mode decoder.
// Shared by the video register block and its bus helpers.
package orion_video_pkg;

  localparam logic [7:0] PORT_MODE = 8'hF8;
  localparam logic [7:0] PORT_BANK = 8'hFA;
  localparam logic [7:0] PORT_PAL  = 8'hFC;
  localparam logic [7:0] PORT_IDX  = 8'hFD;
  localparam logic [7:0] CTL_LO    = 8'h08;
  localparam logic [7:0] CTL_HI    = 8'h0B;
  localparam logic [7:0] CTL_PRO   = 8'h0A;

  localparam logic [2:0] VM_0 = 3'd0;
  localparam logic [2:0] VM_1 = 3'd1;
  localparam logic [2:0] VM_2 = 3'd2;
  localparam logic [2:0] VM_3 = 3'd3;
  localparam logic [2:0] VM_4 = 3'd4;
  localparam logic [2:0] VM_5 = 3'd5;
  localparam logic [2:0] VM_6 = 3'd6;
  localparam logic [2:0] VM_7 = 3'd7;

  // m = {mode[4], mode[2:0]}; mode[3] does not affect the code
  function automatic logic [2:0] mode_decode(
    input logic [3:0] m
  );
    logic [2:0] r;
    r = VM_0;
    unique case (1'b1)
      m[3] & ~m[2]:          r = VM_6;
      m[3] & m[2]:           r = VM_7;
      m == 4'b0000:          r = VM_1;
      m == 4'b0001:          r = VM_2;
      m == 4'b0100:          r = VM_3;
      m == 4'b0101:          r = VM_4;
      m[3:1] == 3'b011:      r = VM_5;
      default:               r = VM_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/orion_bus_wr_edge.sv
// Z80 write-strobe sampler: one wr_pulse per bus write.
// Sample resets high so a write held across reset still fires.
module orion_bus_wr_edge (
  input  logic clk,
  input  logic reset,
  input  logic wr_n,
  output logic wr_pulse
);

  logic wr_q;

  always_ff @(posedge clk) begin
    if (reset) wr_q <= 1'b1;
    else       wr_q <= wr_n;
  end

  assign wr_pulse = ~wr_n & wr_q;

endmodule

// File: rtl/orion_video_regs.sv
// Orion video mode/bank/palette registers with frame-deferred bank.
// ORION_VIDEO_READBACK_EN adds the o_rd_data/o_rd_oe readback bus.
module orion_video_regs
  import orion_video_pkg::*;
#(
  parameter  int BANK_W    = 2,
  parameter  int PAL_DEPTH = 16,
  localparam int IW        = $clog2(PAL_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_iorq_n,
  input  logic              i_mreq_n,
  input  logic              i_rfsh_n,
  input  logic              i_wr_n,
  input  logic              i_rd_n,
  input  logic [15:0]       i_addr,
  input  logic [7:0]        i_data,
  input  logic              i_frame_end,
  output logic [2:0]        o_video_mode,
  output logic [BANK_W-1:0] o_video_bank,
  output logic              o_ps_sel,
  output logic              o_vb_sw,
  output logic              o_wide_scr,
  output logic              o_ps1_str,
  output logic              o_pal_we,
  output logic [IW-1:0]     o_pal_addr,
  output logic [7:0]        o_pal_data
`ifdef ORION_VIDEO_READBACK_EN
  ,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_oe
`endif
);

  logic              wr_pulse;
  logic [4:0]        mode;
  logic [BANK_W-1:0] pend;
  logic [BANK_W-1:0] applied;
  logic              wide;
  logic              pro_en;
  logic [IW-1:0]     idx;
  logic [7:0]        lo;
  logic [7:0]        hi;
  logic              io_wr;
  logic              mem_wr;
  logic              wr_mode;
  logic              wr_bank;
  logic              wr_pal;
  logic              wr_idx;
  logic              wr_ctl;

  orion_bus_wr_edge u_wr_edge (
    .clk      (i_clk),
    .reset    (i_reset),
    .wr_n     (i_wr_n),
    .wr_pulse (wr_pulse)
  );

  assign lo = i_addr[7:0];
  assign hi = i_addr[15:8];

  assign io_wr  = wr_pulse & ~i_iorq_n & i_rd_n;
  assign mem_wr = wr_pulse & pro_en & ~i_mreq_n
                & i_rfsh_n & i_rd_n;

  assign wr_mode = (io_wr && lo == PORT_MODE)
                 || (mem_wr && hi == PORT_MODE);
  assign wr_bank = (io_wr && lo == PORT_BANK)
                 || (mem_wr && hi == PORT_BANK);
  assign wr_pal  = io_wr && lo == PORT_PAL;
  assign wr_idx  = io_wr && lo == PORT_IDX;
  assign wr_ctl  = io_wr && lo >= CTL_LO
                 && lo <= CTL_HI && lo == CTL_PRO;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode       <= '0;
      pend       <= '0;
      applied    <= '0;
      wide       <= 1'b0;
      pro_en     <= 1'b0;
      idx        <= '0;
      o_pal_we   <= 1'b0;
      o_pal_addr <= '0;
      o_pal_data <= '0;
      o_ps1_str  <= 1'b1;
    end else begin
      o_pal_we  <= wr_pal;
      o_ps1_str <= ~wr_pal;
      if (wr_pal) begin
        o_pal_addr <= idx;
        o_pal_data <= i_data;
        idx        <= idx + 1'b1;
      end else if (wr_idx) begin
        idx <= i_data[IW-1:0];
      end
      if (wr_mode) mode <= i_data[4:0];
      if (wr_bank) begin
        pend <= i_data[BANK_W-1:0];
        wide <= i_data[7];
      end
      // frame end latches the pending value from before this edge
      if (i_frame_end) applied <= pend;
      if (wr_ctl) pro_en <= i_data[7];
    end
  end

  assign o_video_mode = mode_decode({mode[4], mode[2:0]});
  assign o_video_bank = ~applied;
  assign o_ps_sel     = mode[3];
  assign o_vb_sw      = mode[4];
  assign o_wide_scr   = wide;

`ifdef ORION_VIDEO_READBACK_EN
  logic [7:0] bank_rd;
  logic [7:0] idx_rd;

  always_comb begin
    bank_rd              = '0;
    bank_rd[7]           = wide;
    bank_rd[BANK_W-1:0]  = pend;
    idx_rd               = '0;
    idx_rd[IW-1:0]       = idx;
    o_rd_data            = '0;
    o_rd_oe              = 1'b0;
    if (~i_iorq_n & ~i_rd_n) begin
      case (lo)
        PORT_MODE: begin
          o_rd_data = {3'b000, mode};
          o_rd_oe   = 1'b1;
        end
        PORT_BANK: begin
          o_rd_data = bank_rd;
          o_rd_oe   = 1'b1;
        end
        PORT_IDX: begin
          o_rd_data = idx_rd;
          o_rd_oe   = 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
